// File: rtl/count_dir_decoder_pkg.sv
// Shared definitions for the count direction decoder: FSM states, step codes
// and direction constants.
package count_dir_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Codes equal the modulo-4 delta they stand for, so classification is a cast.
    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_BAD  = 2'd2,
        STEP_DN   = 2'd3
    } step_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/count_dir_decoder_if.sv
// Sample/result bundle between a count source and the direction decoder.
interface count_dir_decoder_if #(
    parameter int unsigned POS_W = 8
);
    logic                    clr;
    logic [1:0]              q_in;
    logic                    q_valid;
    logic                    dir;
    logic                    dir_valid;
    logic signed [POS_W-1:0] pos;
    logic                    l_out;
    logic                    illegal;
    logic                    fault;

    modport master (
        output clr, q_in, q_valid,
        input  dir, dir_valid, pos, l_out, illegal, fault
    );

    modport slave (
        input  clr, q_in, q_valid,
        output dir, dir_valid, pos, l_out, illegal, fault
    );
endinterface

// File: rtl/dir_step_classify.sv
// Classifies one sample against the previous one as hold/up/down/illegal.
module dir_step_classify
    import count_dir_decoder_pkg::*;
(
    input  logic [1:0] prev,
    input  logic [1:0] q_in,
    output step_t      step
);
    logic [1:0] delta;

    // Modulo-4 difference maps directly onto the step code.
    always_comb begin
        delta = q_in - prev;
        step  = step_t'(delta);
    end
endmodule

// File: rtl/count_dir_decoder.sv
// Recovers direction, position and terminal count from a sampled 2-bit
// modulo-4 count stream, and flags illegal jumps of 2.
// Optional: DIRDEC_GLITCH_FILTER_EN makes dir change only after two
// consecutive legal steps in the new direction.
module count_dir_decoder
    import count_dir_decoder_pkg::*;
#(
    parameter int unsigned POS_W     = 8,
    parameter int unsigned ERR_LIMIT = 3
) (
    input logic                clk,
    input logic                reset,
    count_dir_decoder_if.slave bus
);
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic signed [POS_W-1:0] POS_ONE = 1;
    localparam logic [3:0]              ERR_LIM = 4'(ERR_LIMIT);

    state_t                  state_q, state_d;
    logic [1:0]              prev_q, prev_d;
    logic [3:0]              err_q, err_d;
    logic                    dir_q, dir_d;
    logic                    dir_valid_q, dir_valid_d;
    logic signed [POS_W-1:0] pos_q, pos_d;
    logic                    l_out_q, l_out_d;
    logic                    illegal_q, illegal_d;
    logic                    fault_q, fault_d;
    logic                    step_dir;
    step_t                   step;
`ifdef DIRDEC_GLITCH_FILTER_EN
    logic                    pend_q, pend_d;
`endif

    dir_step_classify u_classify (
        .prev (prev_q),
        .q_in (bus.q_in),
        .step (step)
    );

    // Next-state: FSM, step accumulation, error streak and direction.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        err_d       = err_q;
        dir_d       = dir_q;
        dir_valid_d = 1'b0;
        pos_d       = pos_q;
        l_out_d     = l_out_q;
        illegal_d   = 1'b0;
        fault_d     = fault_q;
        step_dir    = DIR_UP;
`ifdef DIRDEC_GLITCH_FILTER_EN
        pend_d      = pend_q;
`endif
        if (bus.clr) begin
            state_d = IDLE;
            prev_d  = 2'd0;
            err_d   = 4'd0;
            dir_d   = 1'b0;
            pos_d   = '0;
            l_out_d = 1'b0;
            fault_d = 1'b0;
`ifdef DIRDEC_GLITCH_FILTER_EN
            pend_d  = 1'b0;
`endif
        end else if (bus.q_valid) begin
            unique case (state_q)
                IDLE: begin
                    prev_d  = bus.q_in;
                    state_d = TRACK;
                end
                TRACK: begin
                    prev_d = bus.q_in;
                    unique case (step)
                        STEP_HOLD: begin
                            err_d = 4'd0;
`ifdef DIRDEC_GLITCH_FILTER_EN
                            pend_d = 1'b0;
`endif
                        end
                        STEP_BAD: begin
                            illegal_d = 1'b1;
                            err_d     = err_q + 4'd1;
`ifdef DIRDEC_GLITCH_FILTER_EN
                            pend_d    = 1'b0;
`endif
                            if ((err_q + 4'd1) >= ERR_LIM) begin
                                state_d = FAULT;
                                fault_d = 1'b1;
                            end
                        end
                        STEP_UP, STEP_DN: begin
                            err_d       = 4'd0;
                            dir_valid_d = 1'b1;
                            step_dir    = (step == STEP_DN) ? DIR_DN : DIR_UP;
                            if (step_dir == DIR_UP) begin
                                if (pos_q != POS_MAX) pos_d = pos_q + POS_ONE;
                                l_out_d = (bus.q_in == 2'd3);
                            end else begin
                                if (pos_q != POS_MIN) pos_d = pos_q - POS_ONE;
                                l_out_d = (bus.q_in == 2'd0);
                            end
`ifdef DIRDEC_GLITCH_FILTER_EN
                            // A lone opposite step is remembered, not obeyed.
                            if (step_dir == dir_q) begin
                                pend_d = 1'b0;
                            end else if (pend_q) begin
                                dir_d  = step_dir;
                                pend_d = 1'b0;
                            end else begin
                                pend_d = 1'b1;
                            end
`else
                            dir_d = step_dir;
`endif
                        end
                    endcase
                end
                FAULT: begin
                    // Samples ignored until clr or reset.
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs, async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prev_q      <= 2'd0;
            err_q       <= 4'd0;
            dir_q       <= 1'b0;
            dir_valid_q <= 1'b0;
            pos_q       <= '0;
            l_out_q     <= 1'b0;
            illegal_q   <= 1'b0;
            fault_q     <= 1'b0;
`ifdef DIRDEC_GLITCH_FILTER_EN
            pend_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            err_q       <= err_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            pos_q       <= pos_d;
            l_out_q     <= l_out_d;
            illegal_q   <= illegal_d;
            fault_q     <= fault_d;
`ifdef DIRDEC_GLITCH_FILTER_EN
            pend_q      <= pend_d;
`endif
        end
    end

    assign bus.dir       = dir_q;
    assign bus.dir_valid = dir_valid_q;
    assign bus.pos       = pos_q;
    assign bus.l_out     = l_out_q;
    assign bus.illegal   = illegal_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_count_dir_decoder.sv
// Directed bench for count_dir_decoder with a behavioural model feeding an
// expected-result queue; a second instance (POS_W=4) covers saturation.
module tb_count_dir_decoder;

    typedef struct {
        logic               dir;
        logic               dv;
        logic signed [31:0] pos;
        logic               l;
        logic               ill;
        logic               flt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   dv_seen = 0;
    int   ill_seen = 0;
    exp_t sbq[$];

    // Model state for the POS_W=8 / ERR_LIMIT=3 instance.
    int         m_state, m_err, m_pos;
    logic [1:0] m_prev;
    logic       m_dir, m_l, m_fault, m_pend;

    count_dir_decoder_if #(.POS_W(8)) b8 ();
    count_dir_decoder_if #(.POS_W(4)) b4 ();

    count_dir_decoder #(.POS_W(8), .ERR_LIMIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    count_dir_decoder #(.POS_W(4), .ERR_LIMIT(3)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_err = 0; m_pos = 0; m_prev = 2'd0;
        m_dir = 1'b0; m_l = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] q, input logic v, input logic c);
        exp_t       e;
        logic [1:0] d;
        logic       sd;
        e.dv = 1'b0;
        e.ill = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (m_state == 0) begin
                m_prev  = q;
                m_state = 1;
            end else if (m_state == 1) begin
                d = q - m_prev;
                m_prev = q;
                if (d == 2'd0) begin
                    m_err = 0;
                    m_pend = 1'b0;
                end else if (d == 2'd2) begin
                    e.ill = 1'b1;
                    m_err++;
                    m_pend = 1'b0;
                    if (m_err >= 3) begin
                        m_state = 2;
                        m_fault = 1'b1;
                    end
                end else begin
                    e.dv = 1'b1;
                    m_err = 0;
                    sd = (d == 2'd3);
                    if (!sd) begin
                        m_pos = (m_pos < 127) ? m_pos + 1 : 127;
                        m_l = (q == 2'd3);
                    end else begin
                        m_pos = (m_pos > -128) ? m_pos - 1 : -128;
                        m_l = (q == 2'd0);
                    end
`ifdef DIRDEC_GLITCH_FILTER_EN
                    if (sd == m_dir) m_pend = 1'b0;
                    else if (m_pend) begin
                        m_dir = sd;
                        m_pend = 1'b0;
                    end else m_pend = 1'b1;
`else
                    m_dir = sd;
`endif
                end
            end
        end
        e.dir = m_dir;
        e.pos = m_pos;
        e.l   = m_l;
        e.flt = m_fault;
        sbq.push_back(e);
    endtask

    task automatic pop_exp(input string lbl, output exp_t e);
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $error("FAIL %s.queue: observed empty expected entry", lbl);
            e = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        end else begin
            e = sbq.pop_front();
        end
    endtask

    // One sample on the POS_W=8 instance, compared one cycle later.
    task automatic step(input string lbl, input logic [1:0] q, input logic v,
                        input logic c);
        exp_t e;
        b8.q_in = q; b8.q_valid = v; b8.clr = c;
        model_step(q, v, c);
        @(posedge clk);
        #1;
        b8.q_valid = 1'b0; b8.clr = 1'b0;
        pop_exp(lbl, e);
        chk({lbl, ".dir"}, b8.dir, e.dir);
        chk({lbl, ".dir_valid"}, b8.dir_valid, e.dv);
        chk({lbl, ".pos"}, b8.pos, e.pos);
        chk({lbl, ".l_out"}, b8.l_out, e.l);
        chk({lbl, ".illegal"}, b8.illegal, e.ill);
        chk({lbl, ".fault"}, b8.fault, e.flt);
        if (b8.dir_valid === 1'b1) dv_seen++;
        if (b8.illegal === 1'b1) ill_seen++;
    endtask

    // Up step on the POS_W=4 instance; k is the step number (0 = prev load).
    task automatic step4(input int k);
        exp_t       e;
        logic [1:0] q;
        q = 2'(k);
        b4.q_in = q; b4.q_valid = 1'b1; b4.clr = 1'b0;
        e.dir = 1'b0;
        e.dv  = (k != 0);
        e.pos = (k > 7) ? 7 : k;
        e.l   = (k != 0) && (q == 2'd3);
        e.ill = 1'b0;
        e.flt = 1'b0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        b4.q_valid = 1'b0;
        pop_exp($sformatf("sat%0d", k), e);
        chk($sformatf("sat%0d.dir_valid", k), b4.dir_valid, e.dv);
        chk($sformatf("sat%0d.pos", k), b4.pos, e.pos);
        chk($sformatf("sat%0d.l_out", k), b4.l_out, e.l);
    endtask

    initial begin
        b8.clr = 1'b0; b8.q_in = 2'd0; b8.q_valid = 1'b0;
        b4.clr = 1'b0; b4.q_in = 2'd0; b4.q_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.dir", b8.dir, 0);
        chk("rst.dir_valid", b8.dir_valid, 0);
        chk("rst.pos", b8.pos, 0);
        chk("rst.l_out", b8.l_out, 0);
        chk("rst.illegal", b8.illegal, 0);
        chk("rst.fault", b8.fault, 0);
        reset = 1'b1;

        // Counting up with 3->0 wrap.
        dv_seen = 0;
        step("up0", 2'd0, 1'b1, 1'b0);
        step("up1", 2'd1, 1'b1, 1'b0);
        step("up2", 2'd2, 1'b1, 1'b0);
        step("up3", 2'd3, 1'b1, 1'b0);
        chk("up3.l_high", b8.l_out, 1);
        step("up4", 2'd0, 1'b1, 1'b0);
        step("up5", 2'd1, 1'b1, 1'b0);
        chk("up.pos_final", b8.pos, 5);
        chk("up.dv_count", dv_seen, 5);
        step("hold", 2'd1, 1'b1, 1'b0);

        // Counting down with 0->3 wrap.
        step("clr1", 2'd0, 1'b0, 1'b1);
        step("dn0", 2'd3, 1'b1, 1'b0);
        step("dn1", 2'd2, 1'b1, 1'b0);
        step("dn2", 2'd1, 1'b1, 1'b0);
        step("dn3", 2'd0, 1'b1, 1'b0);
        step("dn4", 2'd3, 1'b1, 1'b0);
        chk("dn.pos_final", b8.pos, -4);
        chk("dn.dir_final", b8.dir, 1);

        // Hold between illegal jumps clears the streak.
        step("clr2", 2'd0, 1'b0, 1'b1);
        step("eh0", 2'd0, 1'b1, 1'b0);
        step("eh1", 2'd2, 1'b1, 1'b0);
        step("eh2", 2'd2, 1'b1, 1'b0);
        step("eh3", 2'd0, 1'b1, 1'b0);
        step("eh4", 2'd2, 1'b1, 1'b0);
        step("eh5", 2'd3, 1'b1, 1'b0);
        step("eh6", 2'd1, 1'b1, 1'b0);

        // Three consecutive illegal jumps reach FAULT.
        step("clr3", 2'd0, 1'b0, 1'b1);
        ill_seen = 0;
        step("il0", 2'd0, 1'b1, 1'b0);
        step("il1", 2'd2, 1'b1, 1'b0);
        step("il2", 2'd0, 1'b1, 1'b0);
        step("il3", 2'd2, 1'b1, 1'b0);
        chk("il.count", ill_seen, 3);
        chk("il.fault", b8.fault, 1);
        step("il_ign", 2'd3, 1'b1, 1'b0);
        step("il_clr", 2'd0, 1'b0, 1'b1);
        chk("il.fault_cleared", b8.fault, 0);

        // clr wins over a simultaneous sample.
        step("cv0", 2'd3, 1'b1, 1'b1);
        step("cv1", 2'd0, 1'b1, 1'b0);
        step("cv2", 2'd1, 1'b1, 1'b0);

        // Direction change sequence (glitch filter sensitive).
        step("clr4", 2'd0, 1'b0, 1'b1);
        step("gf0", 2'd0, 1'b1, 1'b0);
        step("gf1", 2'd1, 1'b1, 1'b0);
        step("gf2", 2'd2, 1'b1, 1'b0);
        step("gf3", 2'd1, 1'b1, 1'b0);
        step("gf4", 2'd2, 1'b1, 1'b0);
        step("gf5", 2'd1, 1'b1, 1'b0);
        step("gf6", 2'd0, 1'b1, 1'b0);
        chk("gf.dir_final", b8.dir, 1);

        // Saturation on the narrow instance.
        for (int k = 0; k <= 10; k++) step4(k);

        // Asynchronous reset mid-stream at pos=3.
        step("clr5", 2'd0, 1'b0, 1'b1);
        step("ar0", 2'd0, 1'b1, 1'b0);
        step("ar1", 2'd1, 1'b1, 1'b0);
        step("ar2", 2'd2, 1'b1, 1'b0);
        step("ar3", 2'd3, 1'b1, 1'b0);
        chk("ar.pos_before", b8.pos, 3);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.dir", b8.dir, 0);
        chk("ar.dir_valid", b8.dir_valid, 0);
        chk("ar.pos", b8.pos, 0);
        chk("ar.l_out", b8.l_out, 0);
        chk("ar.illegal", b8.illegal, 0);
        chk("ar.fault", b8.fault, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("ar4", 2'd1, 1'b1, 1'b0);
        step("ar5", 2'd2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/count_dir_decoder.md
Name: count_dir_decoder

Overview:
- Receive-side companion of the 2-bit up/down counter with G-block output.
- Watches a sampled 2-bit count stream `q_in` and recovers the count direction `x` that produced it.
- Tracks a signed position, regenerates the terminal-count output `L`, and flags illegal jumps.
- Sits on the observer side of any block driving a 2-bit modulo-4 count.

Parameters:
- POS_W, 8: width of the signed position accumulator.
- ERR_LIMIT, 3: number of consecutive illegal steps that forces the FAULT state (range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clr  input  1  synchronous re-sync; returns the block to IDLE and zeroes all state.
- q_in  input  2  observed count value.
- q_valid  input  1  `q_in` is a new sample this cycle.
- dir  output  1  recovered direction: 0 = up (+1), 1 = down (-1).
- dir_valid  output  1  one-cycle pulse; a legal step was decoded.
- pos  output  POS_W  signed accumulated position.
- l_out  output  1  regenerated L: 1 while the last legal step landed on the terminal count.
- illegal  output  1  one-cycle pulse; the last sample was a jump of 2.
- fault  output  1  level; the block is in FAULT.

Behaviour:
- Reset (`reset`=0, async): state=IDLE; prev=0; all outputs 0; err_cnt=0.
- All outputs are registered. Each is updated on the clk edge that accepts a sample, i.e. 1-cycle latency.
- Step classification: delta = (q_in - prev) mod 4.
  - delta 0: hold. No pulse; dir, pos and l_out unchanged; err_cnt cleared.
  - delta 1: up. dir=0, pos+1, dir_valid=1.
  - delta 3: down. dir=1, pos-1, dir_valid=1.
  - delta 2: illegal. illegal=1, err_cnt+1; pos, dir and l_out unchanged; prev still updated to q_in.
- Every legal step (up or down) clears err_cnt.
- State IDLE:
  - First q_valid loads prev=q_in and moves to TRACK.
  - No pulses and no pos change on that first sample.
- State TRACK:
  - Classify each q_valid sample as above.
  - Move to FAULT when err_cnt reaches ERR_LIMIT; fault=1 from the same edge that issues the final illegal pulse.
- State FAULT:
  - Samples are ignored; fault=1; pos frozen.
  - Exit only via `clr` (to IDLE) or `reset`.
- l_out on each legal step:
  - Up step: 1 if q_in==3, else 0.
  - Down step: 1 if q_in==0, else 0.
  - Held between legal steps.
- pos saturates at the signed limits: +2^(POS_W-1)-1 and -2^(POS_W-1). On saturation, dir and dir_valid still update.
- `clr` together with q_valid: clr wins and the sample is discarded.
- Reset mid-stream: immediate return to IDLE. The next sample only re-establishes prev.
- Modulo-4 wrap is native: 3→0 is up, 0→3 is down.

Optional Feature:
- Macro: DIRDEC_GLITCH_FILTER_EN.
- When defined, `dir` changes only after two consecutive legal steps in the new direction.
  - The first opposite step still updates pos and pulses dir_valid, but dir keeps its old value.
  - A hold or illegal sample between the two steps resets the filter.
- When undefined, `dir` follows every legal step immediately.

Decomposition:
- Shared include dirdec_defs.vh holds:
  - State encodings IDLE=2'd0, TRACK=2'd1, FAULT=2'd2.
  - Step codes STEP_HOLD, STEP_UP, STEP_DN, STEP_BAD.
  - The direction constants DIR_UP=0, DIR_DN=1.
- One combinational sub-module, dir_step_classify(prev, q_in → step code), reused by any future observer.
- FSM, accumulator and filter stay in the top module.

Test Plan:
- Reset, then q_valid samples 0,1,2,3,0,1 → dir=0 throughout; pos=5; dir_valid pulses 5 times; l_out=1 after the sample 3, 0 after the following 0.
- Samples 3,2,1,0,3 → dir=1; pos=-4; l_out=1 after the sample 0; 3→0 and 0→3 wraps decoded correctly.
- Samples 0,2,0,2 with ERR_LIMIT=3 → 3 illegal pulses; fault=1 on the third; pos=0. A later sample 3 is ignored; clr returns to IDLE with fault=0.
- POS_W=4, 10 up steps → pos saturates at +7; dir_valid still pulses each step.
- Assert reset=0 mid-stream at pos=3 → all outputs 0 asynchronously (before the next clk edge). After release, the first sample produces no dir_valid.
- With DIRDEC_GLITCH_FILTER_EN: up steps, then a single down step, then an up step → dir stays 0; pos net -1 then +1. Two consecutive down steps → dir=1 on the second.
